// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Start/done handshake; result, borrow and zero flag held until the next completion. Rev 1.0
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_res;
  logic                 r_br;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_d;
  logic                 w_br_next;
  logic [WIDTH-1:0]     w_res_next;

  // Full-subtractor cell on the current LSBs; new bit enters the result at the MSB.
  always_comb begin
    w_d        = r_a[0] ^ r_b[0] ^ r_br;
    w_br_next  = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
    w_res_next = {w_d, r_res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_CNT) begin
            diff       <= w_res_next;
            borrow_out <= w_br_next;
            zero       <= (w_res_next == '0);
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
